board_uart_tx: RTL and testbench
================================

BOARD_UART_TX -- requirements
Module: board_uart_tx

Interface
REQ-001 SHALL have parameter HEIGHT, default 20, board rows.
REQ-002 SHALL have parameter WIDTH, default 20, board columns.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 217, clk cycles per UART bit (25 MHz / 115200 baud).
REQ-004 SHALL have port clk  input  1  single clock, the 25 MHz VGA-domain clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port board  input  [0:HEIGHT-1][0:WIDTH-1]  live game board; 1 = alive cell.
REQ-007 SHALL have port start  input  1  single-cycle request to dump the board.
REQ-008 SHALL have port busy  output  1  high while a dump is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse when the last stop bit completes.
REQ-010 SHALL have port tx  output  1  UART serial out, 8N1, idle high.

Function
REQ-011 Top-level FSM SHALL have states IDLE, CELL, CR, LF, FINISH.
REQ-012 In IDLE with start high at edge k: snapshot board into an internal register, clear row/col counters, go to CELL, busy high after edge k.
REQ-013 The snapshot SHALL be the only board source during a dump; board changes after edge k do not affect output.
REQ-014 start while busy SHALL be ignored, with no effect on the stream or counters.
REQ-015 CELL SHALL send byte 0x23 ('#') for alive and 0x2E ('.') for dead, row-major, row 0 col 0 first.
REQ-016 After col WIDTH-1 of a row: CR (0x0D), then LF (0x0A); then the next row, or FINISH after row HEIGHT-1.
REQ-017 The total byte count per dump SHALL be HEIGHT*(WIDTH+2), exactly.
REQ-018 UART framing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each exactly CLKS_PER_BIT cycles.
REQ-019 The first start bit SHALL drive tx low no later than edge k+2.
REQ-020 The idle gap between one stop bit and the next start bit SHALL be at most 2 cycles.
REQ-021 FINISH SHALL pulse done for exactly one cycle after the final stop bit period ends, deassert busy in the same cycle, and return to IDLE.
REQ-022 start coincident with the done cycle SHALL be ignored; a new dump requires start in IDLE.
REQ-023 Counters SHALL be sized $clog2 of their range (minimum 1 bit) and SHALL never exceed HEIGHT-1, WIDTH-1, or CLKS_PER_BIT-1.

Reset
REQ-024 When reset is asserted, asynchronously: FSM to IDLE, busy=0, done=0, tx=1, all counters 0.
REQ-025 Reset mid-byte SHALL force tx high immediately, abort the dump with no done pulse, and require a fresh start afterwards.
REQ-026 The snapshot register need not be reset; it SHALL NOT affect outputs while in IDLE.

Structure
REQ-027 Character constants (CHAR_ALIVE, CHAR_DEAD, CHAR_CR, CHAR_LF) and the FSM state enum SHALL live in shared package gol_pkg.
REQ-028 Byte serialization SHALL be sub-module uart_tx_byte, with a valid/ready byte handshake, a baud counter, and a bit counter, parameterized by CLKS_PER_BIT.
REQ-029 board_uart_tx SHALL hold only the snapshot, the row/col sequencing FSM, and the done/busy logic.

Verification (bench parameters HEIGHT=2, WIDTH=3, CLKS_PER_BIT=4)
REQ-030 board rows 101/010 plus a start pulse -> decoded bytes 23 2E 23 0D 0A 2E 23 2E 0D 0A; one done pulse; busy low afterwards.
REQ-031 Every bit period measured on tx SHALL be exactly 4 cycles; the start bit appears at or before edge k+2; inter-byte gap is at most 2 cycles.
REQ-032 Board inverted and start re-pulsed mid-dump -> output matches the original snapshot, and the second start produces no second dump.
REQ-033 Reset asserted during the 4th byte -> tx=1 and busy=0 immediately, no done pulse; a subsequent start gives a full, correct 10-byte dump.
REQ-034 All-zero board -> bytes 2E 2E 2E 0D 0A 2E 2E 2E 0D 0A; start held high for 3 cycles -> exactly one dump.
REQ-035 Default parameters with random boards -> 440 bytes per dump, and the decoded grid matches the snapshot taken at start.

Source files
------------

// File: rtl/gol_pkg.sv
// gol_pkg: shared constants and state types for the board dump path.
//   CHAR_*        ASCII bytes emitted for cells and line endings
//   gol_state_t   row/col sequencing states of board_uart_tx
//   uart_state_t  framing states of uart_tx_byte
//   cnt_width()   counter width for a range of values, minimum 1 bit
package gol_pkg;

  localparam logic [7:0] CHAR_ALIVE = 8'h23;  // '#'
  localparam logic [7:0] CHAR_DEAD  = 8'h2E;  // '.'
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    CELL,
    CR,
    LF,
    FINISH
  } gol_state_t;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_t;

  function automatic int unsigned cnt_width(input int unsigned range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer with a valid/ready byte handshake.
//   clk, reset   single clock, asynchronous active-high reset
//   valid, data  byte offered; taken on an edge where ready is high
//   ready        high while idle (no frame in flight)
//   tx           serial line, idle high; each bit lasts CLKS_PER_BIT cycles
module uart_tx_byte
  import gol_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned BW = cnt_width(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_t   state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  assign ready = (state == U_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= U_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        U_IDLE: begin
          tx <= 1'b1;
          if (valid) begin
            shreg    <= data;
            baud_cnt <= '0;
            tx       <= 1'b0;
            state    <= U_START;
          end
        end
        U_START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shreg[0];
            state    <= U_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        U_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= U_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        U_STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= U_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= U_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/board_uart_tx.sv
// board_uart_tx: dumps a snapshot of the game board over UART as ASCII,
// one row per line ('#' alive, '.' dead, CR LF after each row).
//   clk    25 MHz clock, all logic on the rising edge
//   reset  asynchronous active-high reset
//   board  live board, row-major, board[0][0] sent first
//   start  request a dump; honoured only in IDLE
//   busy   high while a dump is in progress
//   done   one-cycle pulse once the final stop bit has completed
//   tx     UART 8N1 output, idle high
module board_uart_tx
  import gol_pkg::*;
#(
  parameter int unsigned HEIGHT       = 20,
  parameter int unsigned WIDTH        = 20,
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [0:HEIGHT-1][0:WIDTH-1]      board,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              tx
);

  localparam int unsigned RW = cnt_width(HEIGHT);
  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);

  gol_state_t                   state;
  logic [RW-1:0]                row;
  logic [CW-1:0]                col;
  logic [0:HEIGHT-1][0:WIDTH-1] snap;

  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_data;

  // The done cycle is already spent in IDLE; masking start with done keeps
  // a coincident request from launching a new dump.
  logic take_start;
  assign take_start = (state == IDLE) && start && !done;

  // Snapshot has no reset: it is only read while a dump is active.
  always_ff @(posedge clk) begin
    if (take_start) begin
      snap <= board;
    end
  end

  always_comb begin
    byte_valid = 1'b0;
    byte_data  = CHAR_DEAD;
    case (state)
      CELL: begin
        byte_valid = 1'b1;
        byte_data  = snap[row][col] ? CHAR_ALIVE : CHAR_DEAD;
      end
      CR: begin
        byte_valid = 1'b1;
        byte_data  = CHAR_CR;
      end
      LF: begin
        byte_valid = 1'b1;
        byte_data  = CHAR_LF;
      end
      default: ;
    endcase
  end

  // Sequencing advances on each edge where the serializer accepts a byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (take_start) begin
            row   <= '0;
            col   <= '0;
            busy  <= 1'b1;
            state <= CELL;
          end
        end
        CELL: begin
          if (byte_ready) begin
            if (col == COL_LAST) begin
              col   <= '0;
              state <= CR;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        CR: begin
          if (byte_ready) begin
            state <= LF;
          end
        end
        LF: begin
          if (byte_ready) begin
            if (row == ROW_LAST) begin
              row   <= '0;
              state <= FINISH;
            end else begin
              row   <= row + 1'b1;
              state <= CELL;
            end
          end
        end
        FINISH: begin
          // ready returns once the last stop bit period has elapsed
          if (byte_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk   (clk),
    .reset (reset),
    .valid (byte_valid),
    .data  (byte_data),
    .ready (byte_ready),
    .tx    (tx)
  );

endmodule

// File: tb/tb_board_uart_tx.sv
module tb_board_uart_tx;

  localparam int H   = 2;
  localparam int W   = 3;
  localparam int CPB = 4;
  localparam int BH  = 20;
  localparam int BW  = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic [0:H-1][0:W-1]   board = '0;
  logic [0:BH-1][0:BW-1] board2 = '0;
  logic busy, done, tx;
  logic busy2, done2, tx2;

  always #5 clk = ~clk;

  board_uart_tx #(
    .HEIGHT(H),
    .WIDTH(W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .board(board),
    .start(start),
    .busy (busy),
    .done (done),
    .tx   (tx)
  );

  // Default board size; bit time shortened to keep the run short.
  board_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut_big (
    .clk  (clk),
    .reset(reset),
    .board(board2),
    .start(start2),
    .busy (busy2),
    .done (done2),
    .tx   (tx2)
  );

  bit   sel_big = 1'b0;
  logic mon_tx;
  always_comb mon_tx = sel_big ? tx2 : tx;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int done2_cnt = 0;
  logic [7:0] rx_buf [0:439];

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (done2 === 1'b1) done2_cnt++;
  end

  typedef struct {
    logic [0:H-1][0:W-1] brd;
    logic [79:0]         exp;
    int                  hold;
  } vec_t;

  vec_t vt [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; receives one frame, checking start gap and bit timing.
  task automatic rx_byte(input int gap_limit, output logic [7:0] b);
    int   gap;
    logic first;
    bit   frame_ok;
    gap = 0;
    frame_ok = 1'b1;
    b = '0;
    @(negedge clk);
    while (mon_tx !== 1'b0 && gap <= 50 * CPB) begin
      gap++;
      @(negedge clk);
    end
    check($sformatf("start_gap(%0d)", gap), 64'(gap <= gap_limit), 64'd1);
    if (gap > 50 * CPB) return;
    for (int i = 1; i < CPB; i++) begin
      @(negedge clk);
      if (mon_tx !== 1'b0) frame_ok = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      first = mon_tx;
      b[k] = first;
      for (int i = 1; i < CPB; i++) begin
        @(negedge clk);
        if (mon_tx !== first) frame_ok = 1'b0;
      end
    end
    for (int i = 0; i < CPB; i++) begin
      @(negedge clk);
      if (mon_tx !== 1'b1) frame_ok = 1'b0;
    end
    check("framing", 64'(frame_ok), 64'd1);
  endtask

  task automatic rx_dump(input int n, input int first_limit);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      rx_byte((i == 0) ? first_limit : 2, b);
      rx_buf[i] = b;
    end
  endtask

  task automatic idle_check(input int cycles, input string name);
    bit saw_low;
    saw_low = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (mon_tx !== 1'b1) saw_low = 1'b1;
    end
    check(name, 64'(saw_low), 64'd0);
  endtask

  task automatic compare_bytes(input logic [79:0] exp, input string tag);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("%s_byte%0d", tag, i), 64'(rx_buf[i]), 64'(exp[79-8*i -: 8]));
    end
  endtask

  task automatic run_vec(input int v);
    int d0;
    board = vt[v].brd;
    d0 = done_cnt;
    fork
      begin
        start = 1'b1;
        repeat (vt[v].hold) @(negedge clk);
        start = 1'b0;
      end
      rx_dump(10, 2);
    join
    compare_bytes(vt[v].exp, $sformatf("vec%0d", v));
    repeat (4) @(negedge clk);
    check($sformatf("vec%0d_done_pulses", v), 64'(done_cnt - d0), 64'd1);
    check($sformatf("vec%0d_busy_after", v), 64'(busy), 64'd0);
    idle_check(60, $sformatf("vec%0d_no_extra_dump", v));
  endtask

  initial begin
    int d0;
    int n;
    logic [7:0] e;

    vt[0] = '{brd: 6'b101_010, exp: 80'h23_2E_23_0D_0A_2E_23_2E_0D_0A, hold: 1};
    vt[1] = '{brd: 6'b000_000, exp: 80'h2E_2E_2E_0D_0A_2E_2E_2E_0D_0A, hold: 3};
    vt[2] = '{brd: 6'b111_111, exp: 80'h23_23_23_0D_0A_23_23_23_0D_0A, hold: 1};
    vt[3] = '{brd: 6'b110_001, exp: 80'h23_23_2E_0D_0A_2E_2E_23_0D_0A, hold: 2};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_tx", 64'(tx), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_tx_big", 64'(tx2), 64'd1);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // First-start latency: tx low at or before edge k+2
    board = vt[0].brd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    d0 = done_cnt;
    rx_dump(10, 1);
    compare_bytes(vt[0].exp, "latency");
    repeat (4) @(negedge clk);
    check("latency_done_pulses", 64'(done_cnt - d0), 64'd1);
    repeat (5) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      run_vec(v);
    end

    // Board inverted and start re-pulsed mid-dump
    board = vt[0].brd;
    d0 = done_cnt;
    fork
      begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        board = ~board;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      rx_dump(10, 2);
    join
    compare_bytes(vt[0].exp, "snapshot");
    repeat (4) @(negedge clk);
    check("snapshot_done_pulses", 64'(done_cnt - d0), 64'd1);
    idle_check(100, "snapshot_no_second_dump");

    // Reset during the 4th byte
    board = vt[3].brd;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rx_dump(3, 2);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("abort_byte%0d", i), 64'(rx_buf[i]), 64'(vt[3].exp[79-8*i -: 8]));
    end
    n = 0;
    while (tx !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("abort_4th_start_seen", 64'(tx), 64'd0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_tx_high", 64'(tx), 64'd1);
    check("abort_busy_low", 64'(busy), 64'd0);
    check("abort_done_low", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_check(100, "abort_stays_idle");
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run_vec(3);

    // Default-size board with random contents
    sel_big = 1'b1;
    for (int r = 0; r < BH; r++)
      for (int c = 0; c < BW; c++)
        board2[r][c] = 1'($urandom_range(0, 1));
    d0 = done2_cnt;
    fork
      begin
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
      end
      rx_dump(440, 2);
    join
    n = 0;
    for (int r = 0; r < BH; r++) begin
      for (int c = 0; c < BW + 2; c++) begin
        if (c < BW) e = board2[r][c] ? 8'h23 : 8'h2E;
        else if (c == BW) e = 8'h0D;
        else e = 8'h0A;
        check($sformatf("big_r%0d_c%0d", r, c), 64'(rx_buf[n]), 64'(e));
        n++;
      end
    end
    repeat (4) @(negedge clk);
    check("big_done_pulses", 64'(done2_cnt - d0), 64'd1);
    check("big_busy_after", 64'(busy2), 64'd0);
    idle_check(60, "big_no_extra_bytes");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
